// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default data and register-address widths
//   REQ_A / REQ_B                   : requester indices (ALU path / load path)
//   ZERO_REG                        : the hard-wired zero register
//   age_t                           : relative age of the two holding buffers
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int ZERO_REG = 0;

  // valid=0: the buffers were filled on the same edge (or fewer than two are
  // full), so the round-robin pointer decides. valid=1: 'older' names the
  // buffer that was filled first.
  typedef struct packed {
    logic valid;
    logic older;
  } age_t;

  localparam age_t AGE_CLEAR = '{valid: 1'b0, older: REQ_A};

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry writeback holding buffer.
//   clock, reset_n : clock, asynchronous active-low reset
//   accept         : capture in_addr/in_data and mark the entry full
//   free           : release the entry (ignored when accept refills it)
//   full/addr/data : current entry contents
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              accept,
  input  logic              free,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Accept wins over free: a buffer released on this edge may be refilled on
  // the same edge, which is what sustains one write per cycle per requester.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (free) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between requester A (ALU
// results) and requester B (load data).
//   clock, reset_n           : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data : requester A write handoff
//   b_valid/b_ready/b_addr/b_data : requester B write handoff
//   wr, wd, regwrite         : registered register-file write port
//   commit_b                 : regwrite pulse came from B (0 = from A)
//   busy                     : bit i set while a buffer holds a write to reg i
//
// Handshake: a write transfers on a rising edge where x_valid && x_ready.
// x_ready depends only on buffer state and this cycle's commit/drop decision,
// never on x_valid, so a requester may hold x_valid high and stream one write
// per cycle while ready stays high.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_W-1:0]    a_addr,
  input  logic [DATA_W-1:0]    a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_W-1:0]    b_addr,
  input  logic [DATA_W-1:0]    b_data,
  output logic [ADDR_W-1:0]    wr,
  output logic [DATA_W-1:0]    wd,
  output logic                 regwrite,
  output logic                 commit_b,
  output logic [2**ADDR_W-1:0] busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              full_a, full_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;

  logic accept_a, accept_b;
  logic free_a, free_b;
  logic zero_a, zero_b;
  logic elig_a, elig_b;
  logic grant_a, grant_b, tie;
  logic next_full_a, next_full_b;

  age_t age_q, age_d;
  logic rr_q;

  wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_a (
    .clock   (clock),
    .reset_n (reset_n),
    .accept  (accept_a),
    .free    (free_a),
    .in_addr (a_addr),
    .in_data (a_data),
    .full    (full_a),
    .addr    (addr_a),
    .data    (data_a)
  );

  wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_b (
    .clock   (clock),
    .reset_n (reset_n),
    .accept  (accept_b),
    .free    (free_b),
    .in_addr (b_addr),
    .in_data (b_data),
    .full    (full_b),
    .addr    (addr_b),
    .data    (data_b)
  );

  // Writes to the zero register are discarded one cycle after capture and
  // never take part in arbitration.
  assign zero_a = full_a && (addr_a == ZERO_ADDR);
  assign zero_b = full_b && (addr_b == ZERO_ADDR);
  assign elig_a = full_a && !zero_a;
  assign elig_b = full_b && !zero_b;

  // Oldest first; the round-robin pointer only breaks same-edge ties.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    tie     = 1'b0;
    if (elig_a && elig_b) begin
      if (age_q.valid) begin
        if (age_q.older == REQ_B) grant_b = 1'b1;
        else                      grant_a = 1'b1;
      end else begin
        tie = 1'b1;
        if (rr_q == REQ_B) grant_b = 1'b1;
        else               grant_a = 1'b1;
      end
    end else if (elig_a) begin
      grant_a = 1'b1;
    end else if (elig_b) begin
      grant_b = 1'b1;
    end
  end

  assign free_a  = grant_a || zero_a;
  assign free_b  = grant_b || zero_b;
  assign a_ready = !full_a || free_a;
  assign b_ready = !full_b || free_b;
  assign accept_a = a_valid && a_ready;
  assign accept_b = b_valid && b_ready;

  assign next_full_a = accept_a || (full_a && !free_a);
  assign next_full_b = accept_b || (full_b && !free_b);

  // The buffer that stays full while the other one is (re)filled becomes the
  // older one. Two fills on the same edge leave the age undecided.
  always_comb begin
    age_d = age_q;
    if (!(next_full_a && next_full_b)) begin
      age_d = AGE_CLEAR;
    end else if (accept_a && accept_b) begin
      age_d = AGE_CLEAR;
    end else if (accept_a) begin
      age_d = '{valid: 1'b1, older: REQ_B};
    end else if (accept_b) begin
      age_d = '{valid: 1'b1, older: REQ_A};
    end
  end

  always_comb begin
    busy = '0;
    if (full_a) busy[addr_a] = 1'b1;
    if (full_b) busy[addr_b] = 1'b1;
    busy[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      age_q    <= AGE_CLEAR;
      rr_q     <= REQ_A;
      regwrite <= 1'b0;
      commit_b <= 1'b0;
      wr       <= '0;
      wd       <= '0;
    end else begin
      age_q    <= age_d;
      regwrite <= grant_a || grant_b;
      if (tie) rr_q <= ~rr_q;
      if (grant_b) begin
        wr       <= addr_b;
        wd       <= data_b;
        commit_b <= REQ_B;
      end else if (grant_a) begin
        wr       <= addr_a;
        wd       <= data_a;
        commit_b <= REQ_A;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int NREG   = 2**ADDR_W;
  localparam int W      = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wd;
  logic              regwrite, commit_b;
  logic [NREG-1:0]   busy;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .wr       (wr),
    .wd       (wd),
    .regwrite (regwrite),
    .commit_b (commit_b),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;
  bit sb_on = 1'b0;

  // ---------------- reference model ----------------
  // Pending writes are tracked per requester with the cycle they were accepted;
  // the oldest timestamp wins, equal timestamps go to the round-robin turn.
  logic              m_v[2];
  logic [ADDR_W-1:0] m_addr[2];
  logic [DATA_W-1:0] m_data[2];
  int                m_t[2];
  int                m_rr;
  int                cyc;
  logic              m_regwrite;
  logic [ADDR_W-1:0] last_wr;
  logic [DATA_W-1:0] last_wd;

  logic [W-1:0] exp_q[$];   // expected commit {commit_b, wr, wd}
  logic [W-1:0] seen_q[$];  // observed commits

  task automatic model_clear();
    for (int r = 0; r < 2; r++) begin
      m_v[r] = 1'b0; m_addr[r] = '0; m_data[r] = '0; m_t[r] = 0;
    end
    m_rr = 0; cyc = 0; m_regwrite = 1'b0;
    last_wr = '0; last_wd = '0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  initial begin : scoreboard
    int g;
    bit tie;
    bit drop[2];
    bit cand[2];
    bit er[2];
    bit acc[2];
    logic [ADDR_W-1:0] ia[2];
    logic [DATA_W-1:0] id[2];
    logic [NREG-1:0] eb;
    logic [W-1:0] e;
    forever begin
      @(negedge clock); #3;
      if (sb_on) begin
        for (int r = 0; r < 2; r++) begin
          drop[r] = m_v[r] && (m_addr[r] == '0);
          cand[r] = m_v[r] && (m_addr[r] != '0);
        end
        g = -1; tie = 1'b0;
        if (cand[0] && cand[1]) begin
          if (m_t[0] < m_t[1])      g = 0;
          else if (m_t[1] < m_t[0]) g = 1;
          else begin g = m_rr; tie = 1'b1; end
        end else if (cand[0]) g = 0;
        else if (cand[1])     g = 1;
        for (int r = 0; r < 2; r++) er[r] = !m_v[r] || drop[r] || (g == r);
        tests++;
        if (a_ready !== er[0]) begin
          fails++; $display("FAIL a_ready cyc=%0d got=%b exp=%b", cyc, a_ready, er[0]);
        end
        tests++;
        if (b_ready !== er[1]) begin
          fails++; $display("FAIL b_ready cyc=%0d got=%b exp=%b", cyc, b_ready, er[1]);
        end
        eb = '0;
        for (int r = 0; r < 2; r++) if (cand[r]) eb[m_addr[r]] = 1'b1;
        tests++;
        if (busy !== eb) begin
          fails++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
        end
        acc[0] = a_valid && er[0]; ia[0] = a_addr; id[0] = a_data;
        acc[1] = b_valid && er[1]; ia[1] = b_addr; id[1] = b_data;
      end
      @(posedge clock);
      if (sb_on) begin
        if (g >= 0) begin
          exp_q.push_back({(g == 1), m_addr[g], m_data[g]});
          m_regwrite = 1'b1;
        end else begin
          m_regwrite = 1'b0;
        end
        if (tie) m_rr = 1 - m_rr;
        for (int r = 0; r < 2; r++) begin
          if (drop[r] || (g == r)) m_v[r] = 1'b0;
          if (acc[r]) begin
            m_v[r] = 1'b1; m_addr[r] = ia[r]; m_data[r] = id[r]; m_t[r] = cyc;
          end
        end
        cyc++;
      end
      #1;
      if (sb_on) begin
        tests++;
        if (regwrite !== m_regwrite) begin
          fails++; $display("FAIL regwrite cyc=%0d got=%b exp=%b", cyc, regwrite, m_regwrite);
        end
        if (regwrite === 1'b1) seen_q.push_back({commit_b, wr, wd});
        if (m_regwrite) begin
          e = exp_q.pop_front();
          tests++;
          if ({commit_b, wr, wd} !== e) begin
            fails++;
            $display("FAIL commit cyc=%0d got b=%b wr=%0d wd=%h exp b=%b wr=%0d wd=%h", cyc,
                     commit_b, wr, wd, e[W-1], e[DATA_W+ADDR_W-1:DATA_W], e[DATA_W-1:0]);
          end
          last_wr = e[DATA_W+ADDR_W-1:DATA_W];
          last_wd = e[DATA_W-1:0];
        end else begin
          tests++;
          if (wr !== last_wr || wd !== last_wd) begin
            fails++;
            $display("FAIL hold cyc=%0d got wr=%0d wd=%h exp wr=%0d wd=%h", cyc, wr, wd, last_wr, last_wd);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    @(negedge clock);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #2;
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL rst_regwrite got=%b exp=0", regwrite); end
    tests++; if (wr !== '0)         begin fails++; $display("FAIL rst_wr got=%0d exp=0", wr); end
    tests++; if (wd !== '0)         begin fails++; $display("FAIL rst_wd got=%h exp=0", wd); end
    tests++; if (commit_b !== 1'b0) begin fails++; $display("FAIL rst_commit_b got=%b exp=0", commit_b); end
    tests++; if (busy !== '0)       begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL rst_a_ready got=%b exp=1", a_ready); end
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rst_b_ready got=%b exp=1", b_ready); end
    @(posedge clock); #2;
    sb_on = 1'b1;
  endtask

  task automatic test_single_write();
    seen_q.delete();
    drive(1'b1, 2'd1, 16'h1234, 1'b0, '0, '0);
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL single_a_ready got=%b exp=1", a_ready); end
    idle(1); #1;
    tests++; if (busy !== 4'b0010) begin fails++; $display("FAIL single_busy got=%b exp=0010", busy); end
    idle(3);
    tests++;
    if (seen_q.size() != 1 || seen_q[0] !== {1'b0, 2'd1, 16'h1234}) begin
      fails++; $display("FAIL single_commit got_n=%0d exp_n=1 (addr 1 data 1234 from A)", seen_q.size());
    end
  endtask

  task automatic test_tie();
    seen_q.delete();
    drive(1'b1, 2'd2, 16'hAAAA, 1'b1, 2'd3, 16'h5555);
    idle(4);
    tests++;
    if (seen_q.size() != 2 || seen_q[0] !== {1'b0, 2'd2, 16'hAAAA} || seen_q[1] !== {1'b1, 2'd3, 16'h5555}) begin
      fails++; $display("FAIL tie_first got_n=%0d exp A(2,AAAA) then B(3,5555)", seen_q.size());
    end
    seen_q.delete();
    drive(1'b1, 2'd2, 16'h0A0A, 1'b1, 2'd3, 16'h0B0B);
    idle(4);
    tests++;
    if (seen_q.size() != 2 || seen_q[0] !== {1'b1, 2'd3, 16'h0B0B} || seen_q[1] !== {1'b0, 2'd2, 16'h0A0A}) begin
      fails++; $display("FAIL tie_second got_n=%0d exp B(3,0B0B) then A(2,0A0A)", seen_q.size());
    end
  endtask

  task automatic test_oldest_first();
    seen_q.delete();
    drive(1'b1, 2'd2, 16'h0001, 1'b0, '0, '0);
    drive(1'b0, '0, '0, 1'b1, 2'd2, 16'h0002);
    idle(4);
    tests++;
    if (seen_q.size() != 2 || seen_q[0][DATA_W-1:0] !== 16'h0001 || seen_q[1][DATA_W-1:0] !== 16'h0002) begin
      fails++; $display("FAIL same_addr_order got_n=%0d exp wd 0001 then 0002", seen_q.size());
    end
  endtask

  task automatic test_zero_reg();
    seen_q.delete();
    drive(1'b0, '0, '0, 1'b1, 2'd0, 16'hFFFF);
    #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL zero_accept got=%b exp=1", b_ready); end
    idle(1); #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL zero_ready_next got=%b exp=1", b_ready); end
    tests++; if (busy !== '0)      begin fails++; $display("FAIL zero_busy got=%b exp=0", busy); end
    idle(3);
    tests++; if (seen_q.size() != 0) begin fails++; $display("FAIL zero_no_write got=%0d exp=0", seen_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic first;
    seen_q.delete();
    first = (m_rr == 1);
    for (int i = 0; i < 8; i++)
      drive(1'b1, ADDR_W'($urandom_range(1, 3)), DATA_W'($urandom),
            1'b1, ADDR_W'($urandom_range(1, 3)), DATA_W'($urandom));
    idle(4);
    tests++; if (seen_q.size() != 9) begin fails++; $display("FAIL stream_count got=%0d exp=9", seen_q.size()); end
    if (seen_q.size() > 0) begin
      tests++;
      if (seen_q[0][W-1] !== first) begin fails++; $display("FAIL stream_first got=%b exp=%b", seen_q[0][W-1], first); end
    end
    for (int k = 1; k < seen_q.size(); k++) begin
      tests++;
      if (seen_q[k][W-1] === seen_q[k-1][W-1]) begin
        fails++; $display("FAIL stream_alternate k=%0d got=%b exp=%b", k, seen_q[k][W-1], ~seen_q[k-1][W-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom));
    idle(4);
    #1;
    tests++; if (busy !== '0) begin fails++; $display("FAIL random_drain_busy got=%b exp=0", busy); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL random_drain_queue got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd1, 16'hC0DE, 1'b1, 2'd2, 16'hBEEF);
    drive(1'b1, 2'd3, 16'h7777, 1'b0, '0, '0);
    @(posedge clock); #2;
    sb_on = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++; if (regwrite !== 1'b0) begin fails++; $display("FAIL midrst_regwrite got=%b exp=0", regwrite); end
    tests++; if (busy !== '0)       begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    tests++; if (wr !== '0)         begin fails++; $display("FAIL midrst_wr got=%0d exp=0", wr); end
    tests++; if (wd !== '0)         begin fails++; $display("FAIL midrst_wd got=%h exp=0", wd); end
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen_q.delete();
    @(posedge clock); #2;
    sb_on = 1'b1;
    idle(4);
    tests++; if (seen_q.size() != 0) begin fails++; $display("FAIL midrst_stale got=%0d exp=0", seen_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_oldest_first();
    test_zero_reg();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
